// File: rtl/mem_addr_gen_if.sv
// Command channel between the address generator and the memory transaction engine.
// A command moves on any clock where cmd_valid and cmd_ready are both high.
interface mem_addr_gen_if #(
  parameter int ADDR_W  = 25,
  parameter int BURST_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [BURST_W-1:0] cmd_burst;
  logic               cmd_last;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_burst,
    output cmd_last,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_burst,
    input  cmd_last,
    output cmd_ready
  );
endinterface

// File: rtl/mem_addr_gen.sv
// Memory-domain burst command generator: on a start strobe it latches the test parameters
// and streams fixed, sequential or LFSR-random burst commands over a valid/ready channel.
module mem_addr_gen #(
  parameter int          ADDR_W    = 25,
  parameter int          BURST_W   = 8,
  parameter logic [31:0] LFSR_SEED = 32'h1ACE_B00C
) (
  input  logic               clk_mem_i,
  input  logic               rst_n_i,
  input  logic               test_start_i,
  input  logic [1:0]         test_mode_i,
  input  logic [31:0]        test_count_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  mem_addr_gen_if.master     cmd,
  output logic               busy_o,
  output logic               test_finished_o,
  output logic [31:0]        cmd_sent_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0]  MODE_FIXED  = 2'd0;
  localparam logic [1:0]  MODE_RANDOM = 2'd2;
  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

  state_t             r_state;
  logic [1:0]         r_mode;
  logic [31:0]        r_count;
  logic [ADDR_W-1:0]  r_start_addr;
  logic [31:0]        r_lfsr;
  logic               r_cmd_valid;
  logic [ADDR_W-1:0]  r_cmd_addr;
  logic [BURST_W-1:0] r_cmd_burst;
  logic               r_cmd_last;
  logic               r_busy;
  logic               r_finished;
  logic [31:0]        r_cmd_sent;

  logic               w_xfer;
  logic [31:0]        w_next_lfsr;
  logic [31:0]        w_lfsr_init;
  logic               w_next_is_last;
  logic [31:0]        w_sent_inc;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1; a zero start address would lock it up, hence the seed.
  always_comb begin
    w_xfer         = r_cmd_valid && cmd.cmd_ready;
    w_next_lfsr    = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    w_lfsr_init    = (r_start_addr == '0) ? LFSR_SEED : 32'(r_start_addr);
    w_next_is_last = ({1'b0, r_cmd_sent} + 33'd2) == {1'b0, r_count};
    w_sent_inc     = (r_cmd_sent == '1) ? r_cmd_sent : r_cmd_sent + 32'd1;
  end

  always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_mode       <= '0;
      r_count      <= '0;
      r_start_addr <= '0;
      r_lfsr       <= LFSR_SEED;
      r_cmd_valid  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_burst  <= '0;
      r_cmd_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_cmd_sent   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (test_start_i) begin
            r_state      <= LOAD;
            r_mode       <= test_mode_i;
            r_count      <= test_count_i;
            r_start_addr <= start_addr_i;
            r_cmd_burst  <= (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
            r_cmd_sent   <= '0;
            r_finished   <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        LOAD: begin
          r_lfsr     <= w_lfsr_init;
          r_cmd_addr <= (r_mode == MODE_RANDOM) ? w_lfsr_init[ADDR_W-1:0] : r_start_addr;
          if (r_count == '0) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end else begin
            r_state     <= RUN;
            r_cmd_valid <= 1'b1;
            r_cmd_last  <= (r_count == 32'd1);
          end
        end

        RUN: begin
          if (w_xfer) begin
            r_cmd_sent <= w_sent_inc;
            if (r_cmd_last) begin
              r_state     <= DONE;
              r_cmd_valid <= 1'b0;
              r_cmd_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_finished  <= 1'b1;
            end else begin
              r_cmd_last <= w_next_is_last;
              case (r_mode)
                MODE_FIXED: r_cmd_addr <= r_cmd_addr;
                MODE_RANDOM: begin
                  r_lfsr     <= w_next_lfsr;
                  r_cmd_addr <= w_next_lfsr[ADDR_W-1:0];
                end
                default: r_cmd_addr <= r_cmd_addr + ADDR_W'(r_cmd_burst);
              endcase
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_valid   = r_cmd_valid;
  assign cmd.cmd_addr    = r_cmd_addr;
  assign cmd.cmd_burst   = r_cmd_burst;
  assign cmd.cmd_last    = r_cmd_last;
  assign busy_o          = r_busy;
  assign test_finished_o = r_finished;
  assign cmd_sent_o      = r_cmd_sent;

endmodule

// File: tb/tb_mem_addr_gen.sv
// Self-checking bench for mem_addr_gen: directed vector table, randomized tests against a
// queue-based address model, a restart-ignored case and an asynchronous reset mid-test.
module tb_mem_addr_gen;

  localparam int          ADDR_W    = 25;
  localparam int          BURST_W   = 8;
  localparam logic [31:0] LFSR_SEED = 32'h1ACE_B00C;

  typedef struct {
    logic [1:0]         mode;
    logic [31:0]        count;
    logic [BURST_W-1:0] burst;
    logic [ADDR_W-1:0]  start;
    int                 readyPat;
    bit                 useConst;
    logic [ADDR_W-1:0]  firstAddr;
    logic [ADDR_W-1:0]  lastAddr;
    logic [BURST_W-1:0] expBurst;
    int                 injectAt;
  } vec_t;

  logic               clkMem;
  logic               rstN;
  logic               testStart;
  logic [1:0]         testMode;
  logic [31:0]        testCount;
  logic [BURST_W-1:0] burstLen;
  logic [ADDR_W-1:0]  startAddr;
  logic               busy;
  logic               testFinished;
  logic [31:0]        cmdSent;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] expAddr[$];
  vec_t vecs[8];

  mem_addr_gen_if #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) cmdIf ();

  mem_addr_gen #(
    .ADDR_W   (ADDR_W),
    .BURST_W  (BURST_W),
    .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk_mem_i      (clkMem),
    .rst_n_i        (rstN),
    .test_start_i   (testStart),
    .test_mode_i    (testMode),
    .test_count_i   (testCount),
    .burst_len_i    (burstLen),
    .start_addr_i   (startAddr),
    .cmd            (cmdIf),
    .busy_o         (busy),
    .test_finished_o(testFinished),
    .cmd_sent_o     (cmdSent)
  );

  initial clkMem = 1'b0;
  always #5 clkMem = ~clkMem;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One step of the feedback polynomial x^32+x^22+x^2+x+1 in right-shift form.
  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Reference model: the full list of command addresses the test should produce.
  task automatic buildExpected(input vec_t v);
    logic [31:0]       s;
    logic [ADDR_W:0]   a;
    int unsigned       b;
    expAddr.delete();
    b = (v.burst == 0) ? 1 : int'(v.burst);
    s = (v.start == 0) ? LFSR_SEED : 32'(v.start);
    a = {1'b0, v.start};
    for (int unsigned i = 0; i < v.count; i++) begin
      case (v.mode)
        2'd0: expAddr.push_back(v.start);
        2'd2: begin
          expAddr.push_back(s[ADDR_W-1:0]);
          s = lfsrStep(s);
        end
        default: begin
          expAddr.push_back(a[ADDR_W-1:0]);
          a = (a + (ADDR_W+1)'(b)) % (ADDR_W+1)'(1 << ADDR_W);
        end
      endcase
    end
  endtask

  function automatic bit readyFor(input int pat, input int cyc);
    case (pat)
      0: return 1'b1;
      1: return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'(($urandom & 32'h1) == 0);
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v);
    int unsigned idx;
    int          cyc;
    int          budget;
    bit          rdy;
    logic [BURST_W-1:0] effBurst;
    buildExpected(v);
    effBurst = (v.burst == 0) ? BURST_W'(1) : v.burst;
    budget   = int'(v.count) * 8 + 50;

    @(negedge clkMem);
    testMode  = v.mode;
    testCount = v.count;
    burstLen  = v.burst;
    startAddr = v.start;
    testStart = 1'b1;
    cmdIf.cmd_ready = 1'b0;

    @(negedge clkMem);
    testStart = 1'b0;
    checkOutput("load_valid", 64'(cmdIf.cmd_valid), 64'd0);
    checkOutput("load_busy", 64'(busy), 64'd1);
    checkOutput("load_finished", 64'(testFinished), 64'd0);
    checkOutput("load_sent", 64'(cmdSent), 64'd0);

    idx = 0;
    cyc = 0;
    while (idx < v.count && cyc < budget) begin
      @(negedge clkMem);
      rdy = readyFor(v.readyPat, cyc);
      cmdIf.cmd_ready = rdy;
      checkOutput("run_valid", 64'(cmdIf.cmd_valid), 64'd1);
      checkOutput("run_addr", 64'(cmdIf.cmd_addr), 64'(expAddr[idx]));
      checkOutput("run_burst", 64'(cmdIf.cmd_burst), 64'(effBurst));
      checkOutput("run_last", 64'(cmdIf.cmd_last), 64'(idx == v.count - 1));
      checkOutput("run_sent", 64'(cmdSent), 64'(idx));
      checkOutput("run_finished", 64'(testFinished), 64'd0);
      checkOutput("run_busy", 64'(busy), 64'd1);
      if (v.useConst && idx == 0)
        checkOutput("first_addr", 64'(cmdIf.cmd_addr), 64'(v.firstAddr));
      if (v.useConst && idx == v.count - 1)
        checkOutput("last_addr", 64'(cmdIf.cmd_addr), 64'(v.lastAddr));
      if (v.useConst)
        checkOutput("const_burst", 64'(cmdIf.cmd_burst), 64'(v.expBurst));
      if (cyc == v.injectAt) begin
        testStart = 1'b1;
        testCount = 32'd5;
        testMode  = 2'd0;
      end else begin
        testStart = 1'b0;
      end
      if (rdy) idx++;
      cyc++;
    end
    testStart = 1'b0;
    if (cyc >= budget)
      checkOutput("run_timeout", 64'(idx), 64'(v.count));

    @(negedge clkMem);
    cmdIf.cmd_ready = 1'b0;
    checkOutput("done_valid", 64'(cmdIf.cmd_valid), 64'd0);
    checkOutput("done_last", 64'(cmdIf.cmd_last), 64'd0);
    checkOutput("done_finished", 64'(testFinished), 64'd1);
    checkOutput("done_busy", 64'(busy), 64'd0);
    checkOutput("done_sent", 64'(cmdSent), 64'(v.count));
    @(negedge clkMem);
    checkOutput("idle_valid", 64'(cmdIf.cmd_valid), 64'd0);
    checkOutput("idle_finished", 64'(testFinished), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 64'(cmdIf.cmd_valid), 64'd0);
    checkOutput({tag, "_addr"}, 64'(cmdIf.cmd_addr), 64'd0);
    checkOutput({tag, "_burst"}, 64'(cmdIf.cmd_burst), 64'd0);
    checkOutput({tag, "_last"}, 64'(cmdIf.cmd_last), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_finished"}, 64'(testFinished), 64'd0);
    checkOutput({tag, "_sent"}, 64'(cmdSent), 64'd0);
  endtask

  initial begin
    vec_t r;
    int   waitCyc;

    // mode, count, burst, start, readyPat, useConst, first, last, expBurst, injectAt
    vecs[0] = '{2'd1, 32'd4,    8'd4, 25'h0000100, 0, 1'b1, 25'h0000100, 25'h000010C, 8'd4, -1};
    vecs[1] = '{2'd1, 32'd4,    8'd4, 25'h0000100, 1, 1'b1, 25'h0000100, 25'h000010C, 8'd4, -1};
    vecs[2] = '{2'd1, 32'd3,    8'd0, 25'h1FFFFFE, 0, 1'b1, 25'h1FFFFFE, 25'h0000000, 8'd1, -1};
    vecs[3] = '{2'd1, 32'd0,    8'd4, 25'h0000100, 0, 1'b0, 25'h0,       25'h0,       8'd0, -1};
    vecs[4] = '{2'd0, 32'd5,    8'd7, 25'h0000055, 2, 1'b1, 25'h0000055, 25'h0000055, 8'd7, -1};
    vecs[5] = '{2'd3, 32'd3,    8'd2, 25'h0000010, 1, 1'b1, 25'h0000010, 25'h0000014, 8'd2, -1};
    vecs[6] = '{2'd2, 32'd1000, 8'd1, 25'h0000000, 0, 1'b1, 25'h0CEB00C, 25'h0,       8'd1, 10};
    vecs[7] = '{2'd2, 32'd20,   8'd3, 25'h0001234, 2, 1'b0, 25'h0001234, 25'h0,       8'd3, -1};
    // The long random run has no hand-derived last address; only its first one is pinned.
    vecs[6].useConst = 1'b0;

    rstN      = 1'b0;
    testStart = 1'b0;
    testMode  = 2'd0;
    testCount = 32'd0;
    burstLen  = '0;
    startAddr = '0;
    cmdIf.cmd_ready = 1'b0;

    #12;
    checkResetState("reset");
    @(negedge clkMem);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      if (i == 6) begin
        checkOutput("rand_first_seed", 64'(expAddr[0]), 64'(vecs[6].firstAddr));
      end
    end

    for (int i = 0; i < 6; i++) begin
      r.mode      = 2'($urandom_range(0, 3));
      r.count     = 32'($urandom_range(1, 40));
      r.burst     = BURST_W'($urandom);
      r.start     = ADDR_W'($urandom);
      r.readyPat  = 2;
      r.useConst  = 1'b0;
      r.firstAddr = '0;
      r.lastAddr  = '0;
      r.expBurst  = '0;
      r.injectAt  = -1;
      applyStimulus(r);
    end

    // Reset asserted asynchronously with command 5 of 10 on the bus.
    @(negedge clkMem);
    testMode  = 2'd1;
    testCount = 32'd10;
    burstLen  = 8'd1;
    startAddr = 25'h0000200;
    testStart = 1'b1;
    cmdIf.cmd_ready = 1'b1;
    @(negedge clkMem);
    testStart = 1'b0;
    waitCyc = 0;
    while (cmdSent != 32'd5 && waitCyc < 40) begin
      @(negedge clkMem);
      waitCyc++;
    end
    checkOutput("rst_wait_sent", 64'(cmdSent), 64'd5);
    checkOutput("rst_mid_valid", 64'(cmdIf.cmd_valid), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkResetState("midrst");
    @(negedge clkMem);
    checkResetState("midrst_hold");
    rstN = 1'b1;
    cmdIf.cmd_ready = 1'b0;

    r = '{2'd1, 32'd10, 8'd1, 25'h0000200, 1, 1'b1, 25'h0000200, 25'h0000209, 8'd1, -1};
    applyStimulus(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
